// File: rtl/regfile_param_if.sv
// Register file access bus: clear request/busy handshake, two read ports and
// one write port. The pipeline side drives through the master modport, and
// the register file implements the slave side.
interface regfile_param_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clear_req;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              reg_dst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    modport master (
        output clear_req, rd_en, rs_addr, rt_addr, rd_addr, reg_dst, wr_en, wr_data,
        input  busy, rs_data, rt_data
    );

    modport slave (
        input  clear_req, rd_en, rs_addr, rt_addr, rd_addr, reg_dst, wr_en, wr_data,
        output busy, rs_data, rt_data
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with a hardware clear sequencer,
// registered reads, optional write-to-read bypass and an optional hardwired
// zero register. All storage is zeroed by the clear sequence after reset.
module regfile_param #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input logic            clk,
    input logic            rst,
    regfile_param_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] waddr;
    logic              wr_ok;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    // Value a read port would observe at address a in the current cycle.
    function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a);
        if (state == ST_CLEAR)
            return '0;
        else if (ZERO_REG && (a == '0))
            return '0;
        else if (BYPASS && wr_ok && (waddr == a))
            return bus.wr_data;
        else
            return mem[a];
    endfunction

    // State register and clear counter; reset (re)starts the clear sequence.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
            else if (bus.clear_req)
                clr_cnt <= '0;
        end
    end

    // Next-state logic: CLEAR walks every entry once, RUN re-enters CLEAR on request.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
        state_nx = state;
        case (state)
            ST_CLEAR: if (clr_cnt == ADDR_W'(DEPTH - 1)) state_nx = ST_RUN;
            ST_RUN:   if (bus.clear_req) state_nx = ST_CLEAR;
            default:  state_nx = ST_CLEAR;
        endcase
    end

    // FSM output: busy for the whole clear sequence.
    always_comb begin
        bus.busy = (state == ST_CLEAR);
    end

    // Write qualification: RUN only, dropped by a clear request or a zero-register target.
    always_comb begin
        waddr = bus.reg_dst ? bus.rd_addr : bus.rt_addr;
        wr_ok = !rst && bus.wr_en && (state == ST_RUN) && !bus.clear_req
                && !(ZERO_REG && (waddr == '0));
    end

    // Storage: the clear sequencer and the write port share one write path.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset term; the clear sequence zeroes it so it maps onto plain RAM/flops.
        if (!rst && (state == ST_CLEAR))
            mem[clr_cnt] <= '0;
        else if (wr_ok)
            mem[waddr] <= bus.wr_data;
    end

    // Combinational read values, including bypass and zero-register handling.
    always_comb begin
        rs_val = read_val(bus.rs_addr);
        rt_val = read_val(bus.rt_addr);
    end

    // Registered read ports: load on rd_en, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rs_data <= '0;
            bus.rt_data <= '0;
        end else if (bus.rd_en) begin
            bus.rs_data <= rs_val;
            bus.rt_data <= rt_val;
        end
    end
endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param. Two instances share one stimulus:
// config 0 uses BYPASS=1/ZERO_REG=0, config 1 uses BYPASS=0/ZERO_REG=1.
// A behavioural model predicts each cycle's outputs into a scoreboard queue,
// which is popped and compared after the clock edge.
module tb_regfile_param;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    typedef struct packed {
        logic [1:0][DATA_W-1:0] rs;
        logic [1:0][DATA_W-1:0] rt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic clear_req, rd_en, reg_dst, wr_en;
    logic [ADDR_W-1:0] rs_addr, rt_addr, rd_addr;
    logic [DATA_W-1:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    bit cfg_bypass [2] = '{1'b1, 1'b0};
    bit cfg_zero   [2] = '{1'b0, 1'b1};

    logic [DATA_W-1:0] mdl_mem [2][DEPTH];
    bit                mdl_busy = 1'b1;
    int                mdl_cnt  = 0;
    logic [DATA_W-1:0] last_rs [2];
    logic [DATA_W-1:0] last_rt [2];
    exp_t              sb [$];

    regfile_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) if_a ();
    regfile_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) if_b ();

    assign if_a.clear_req = clear_req;
    assign if_a.rd_en     = rd_en;
    assign if_a.rs_addr   = rs_addr;
    assign if_a.rt_addr   = rt_addr;
    assign if_a.rd_addr   = rd_addr;
    assign if_a.reg_dst   = reg_dst;
    assign if_a.wr_en     = wr_en;
    assign if_a.wr_data   = wr_data;
    assign if_b.clear_req = clear_req;
    assign if_b.rd_en     = rd_en;
    assign if_b.rs_addr   = rs_addr;
    assign if_b.rt_addr   = rt_addr;
    assign if_b.rd_addr   = rd_addr;
    assign if_b.reg_dst   = reg_dst;
    assign if_b.wr_en     = wr_en;
    assign if_b.wr_data   = wr_data;

    regfile_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    regfile_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_val(input int c, input logic [ADDR_W-1:0] a,
                                                    input logic [ADDR_W-1:0] wa, input bit wok);
        if (mdl_busy)                          return '0;
        if (cfg_zero[c] && a == 0)             return '0;
        if (cfg_bypass[c] && wok && wa == a)   return wr_data;
        return mdl_mem[c][a];
    endfunction

    // One clock cycle: predict, clock, update model, compare.
    task automatic step();
        logic [ADDR_W-1:0] wa;
        bit                wok [2];
        exp_t              e;
        exp_t              got;
        wa = reg_dst ? rd_addr : rt_addr;
        for (int c = 0; c < 2; c++) begin
            wok[c] = !rst && !mdl_busy && wr_en && !clear_req && !(cfg_zero[c] && wa == 0);
            if (rst) begin
                e.rs[c] = '0;
                e.rt[c] = '0;
            end else if (rd_en) begin
                e.rs[c] = model_val(c, rs_addr, wa, wok[c]);
                e.rt[c] = model_val(c, rt_addr, wa, wok[c]);
            end else begin
                e.rs[c] = last_rs[c];
                e.rt[c] = last_rt[c];
            end
            last_rs[c] = e.rs[c];
            last_rt[c] = e.rt[c];
        end
        sb.push_back(e);

        @(posedge clk);
        for (int c = 0; c < 2; c++)
            if (wok[c]) mdl_mem[c][wa] = wr_data;
        if (rst) begin
            mdl_busy = 1'b1;
            mdl_cnt  = 0;
        end else if (mdl_busy) begin
            if (mdl_cnt == DEPTH - 1) mdl_busy = 1'b0;
            else                      mdl_cnt++;
        end else if (clear_req) begin
            mdl_busy = 1'b1;
            mdl_cnt  = 0;
        end
        if (mdl_busy)
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < DEPTH; i++) mdl_mem[c][i] = '0;

        #1;
        check("busy_a", 32'(if_a.busy), 32'(mdl_busy));
        check("busy_b", 32'(if_b.busy), 32'(mdl_busy));
        got.rs = {if_b.rs_data, if_a.rs_data};
        got.rt = {if_b.rt_data, if_a.rt_data};
        e = sb.pop_front();
        check("rs_a", 32'(got.rs[0]), 32'(e.rs[0]));
        check("rt_a", 32'(got.rt[0]), 32'(e.rt[0]));
        check("rs_b", 32'(got.rs[1]), 32'(e.rs[1]));
        check("rt_b", 32'(got.rt[1]), 32'(e.rt[1]));
    endtask

    task automatic idle();
        clear_req = 1'b0; rd_en = 1'b0; wr_en = 1'b0; reg_dst = 1'b0;
        rs_addr = '0; rt_addr = '0; rd_addr = '0; wr_data = '0;
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        idle();
        wr_en = 1'b1; reg_dst = 1'b1; rd_addr = a; wr_data = d;
        step();
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            rd_en = 1'b1; rs_addr = ADDR_W'(i); rt_addr = ADDR_W'(DEPTH - 1 - i);
            step();
        end
    endtask

    initial begin
        idle();

        // Reset for two cycles, then the 16-cycle clear sequence.
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) step();
        read_all();

        // Write via rd_addr, then via rt_addr; r5 must be untouched by the second.
        write_reg(4'd5, 16'hBEEF);
        idle(); rd_en = 1'b1; rs_addr = 4'd5; step();
        idle(); wr_en = 1'b1; reg_dst = 1'b0; rt_addr = 4'd3; wr_data = 16'h1234; step();
        idle(); rd_en = 1'b1; rs_addr = 4'd3; rt_addr = 4'd5; step();
        idle(); step();   // outputs hold with rd_en low

        // Same-cycle bypass on both ports (config 1 sees the old 0x0001).
        write_reg(4'd7, 16'h0001);
        idle(); wr_en = 1'b1; reg_dst = 1'b1; rd_addr = 4'd7; wr_data = 16'hA5A5;
        rd_en = 1'b1; rs_addr = 4'd7; rt_addr = 4'd7; step();
        idle(); rd_en = 1'b1; rs_addr = 4'd7; rt_addr = 4'd7; step();

        // Zero register: write 0xFFFF to r0 with same-cycle read, then plain read.
        idle(); wr_en = 1'b1; reg_dst = 1'b1; rd_addr = 4'd0; wr_data = 16'hFFFF;
        rd_en = 1'b1; rs_addr = 4'd0; rt_addr = 4'd0; step();
        idle(); rd_en = 1'b1; rs_addr = 4'd0; rt_addr = 4'd7; step();

        // Fill r1..r15, then clear request with a simultaneous write to r2.
        for (int i = 1; i < DEPTH; i++) write_reg(ADDR_W'(i), 16'(i * 16'h1111 + 1));
        read_all();
        idle(); clear_req = 1'b1; wr_en = 1'b1; reg_dst = 1'b1; rd_addr = 4'd2; wr_data = 16'h7777;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            wr_en = 1'b1; reg_dst = 1'b1; rd_addr = ADDR_W'(i); wr_data = 16'($urandom_range(1, 16'hFFFF));
            rd_en = 1'b1; rs_addr = ADDR_W'(i); rt_addr = 4'd2; clear_req = 1'b1;
            step();
        end
        read_all();

        // Reset in the middle of a clear restarts the sequence.
        for (int i = 1; i < DEPTH; i++) write_reg(ADDR_W'(i), 16'(16'hF000 | i));
        idle(); clear_req = 1'b1; step();
        idle();
        for (int i = 0; i < 8; i++) step();
        rst = 1'b1; step();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idle(); wr_en = 1'b1; reg_dst = 1'b1; rd_addr = ADDR_W'(i); wr_data = 16'hDEAD;
            step();
        end
        read_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
